// File: rtl/sprite_motion_ctrl.sv
// Tile-aligned movement controller for one maze sprite: buffers turn requests,
// probes the maze ROM for walls at tile boundaries and steps SPEED px per frame tick.
module sprite_motion_ctrl #(
    parameter int COORD_W = 10,
    parameter int TILE    = 28,
    parameter int SPEED   = 4,
    parameter int X_INI   = 300,
    parameter int Y_INI   = 300,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 639,
    parameter int Y_MIN   = 0,
    parameter int Y_MAX   = 479
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               ack,
    input  logic               tick,
    input  logic [3:0]         dir_req,
    input  logic               win,
    input  logic               lose,
    output logic               probe_req,
    output logic [COORD_W-1:0] probe_x,
    output logic [COORD_W-1:0] probe_y,
    input  logic               probe_ack,
    input  logic               probe_wall,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [3:0]         dir,
    output logic [2:0]         fsm_state,
    output logic               tick_drop
);

    localparam int SUB_W = $clog2(TILE);

    typedef enum logic [2:0] {
        S_INI   = 3'd0,
        S_STILL = 3'd1,
        S_PROBE = 3'd2,
        S_MOVE  = 3'd3,
        S_WIN   = 3'd4,
        S_LOSE  = 3'd5
    } state_t;

    state_t             state;
    logic [3:0]         pend;
    logic [3:0]         cand;
    logic [3:0]         alt;
    logic [SUB_W-1:0]   sub;

    logic [3:0]         c0, c1, nxt_c, step_d;
    logic               nxt_in, aligned, req_ok;
    int                 nx, ny;
    logic [COORD_W-1:0] step_x, step_y;
    logic [SUB_W-1:0]   sub_inc;

    assign fsm_state = state;
    assign aligned   = (sub == '0);
    assign req_ok    = $onehot(dir_req);

    // Candidate order at a tile boundary: a pending turn first, then the current heading.
    always_comb begin
        if (pend != 4'd0 && pend != dir) begin
            c0 = pend;
            c1 = dir;
        end else begin
            c0 = dir;
            c1 = 4'd0;
        end
    end

    // Neighbour tile of the candidate about to be probed; off-map counts as wall.
    always_comb begin
        nxt_c = (state == S_PROBE) ? alt : c0;
        nx    = int'(pos_x);
        ny    = int'(pos_y);
        if (nxt_c[3]) nx = nx - TILE;
        if (nxt_c[1]) nx = nx + TILE;
        if (nxt_c[2]) ny = ny - TILE;
        if (nxt_c[0]) ny = ny + TILE;
        nxt_in = (nx >= X_MIN) && (nx <= X_MAX) && (ny >= Y_MIN) && (ny <= Y_MAX);
    end

    always_comb begin
        step_d = (state == S_PROBE) ? cand : dir;
        step_x = pos_x;
        step_y = pos_y;
        if (step_d[3]) step_x = pos_x - COORD_W'(SPEED);
        if (step_d[1]) step_x = pos_x + COORD_W'(SPEED);
        if (step_d[2]) step_y = pos_y - COORD_W'(SPEED);
        if (step_d[0]) step_y = pos_y + COORD_W'(SPEED);
        sub_inc = (int'(sub) + SPEED >= TILE) ? '0 : sub + SUB_W'(SPEED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_INI;
            pos_x     <= COORD_W'(X_INI);
            pos_y     <= COORD_W'(Y_INI);
            dir       <= 4'd0;
            pend      <= 4'd0;
            sub       <= '0;
            cand      <= 4'd0;
            alt       <= 4'd0;
            probe_req <= 1'b0;
            probe_x   <= '0;
            probe_y   <= '0;
            tick_drop <= 1'b0;
        end else begin
            tick_drop <= 1'b0;
            if (req_ok) pend <= dir_req;
            case (state)
                S_INI: begin
                    if (start) state <= S_STILL;
                end
                S_STILL, S_MOVE: begin
                    if (lose) begin
                        state <= S_LOSE;
                    end else if (win) begin
                        state <= S_WIN;
                    end else if (tick) begin
                        if (!aligned) begin
                            pos_x <= step_x;
                            pos_y <= step_y;
                            sub   <= sub_inc;
                        end else if (c0 != 4'd0) begin
                            state     <= S_PROBE;
                            cand      <= c0;
                            alt       <= c1;
                            probe_req <= nxt_in;
                            probe_x   <= nx[COORD_W-1:0];
                            probe_y   <= ny[COORD_W-1:0];
                        end else begin
                            state <= S_STILL;
                        end
                    end
                end
                S_PROBE: begin
                    if (tick) tick_drop <= 1'b1;
                    if (lose) begin
                        state     <= S_LOSE;
                        probe_req <= 1'b0;
                    end else if (win) begin
                        state     <= S_WIN;
                        probe_req <= 1'b0;
                    end else if (!probe_req || probe_ack) begin
                        if (probe_req && !probe_wall) begin
                            state     <= S_MOVE;
                            dir       <= cand;
                            pos_x     <= step_x;
                            pos_y     <= step_y;
                            sub       <= SUB_W'(SPEED % TILE);
                            probe_req <= 1'b0;
                            if (pend == cand && !req_ok) pend <= 4'd0;
                        end else if (alt != 4'd0) begin
                            cand      <= alt;
                            alt       <= 4'd0;
                            probe_req <= nxt_in;
                            probe_x   <= nx[COORD_W-1:0];
                            probe_y   <= ny[COORD_W-1:0];
                        end else begin
                            // Every candidate blocked: only stop if the heading itself hit the wall.
                            state     <= S_STILL;
                            probe_req <= 1'b0;
                            if (cand == dir) dir <= 4'd0;
                        end
                    end
                end
                S_WIN, S_LOSE: begin
                    if (ack) begin
                        state <= S_INI;
                        pos_x <= COORD_W'(X_INI);
                        pos_y <= COORD_W'(Y_INI);
                        dir   <= 4'd0;
                        pend  <= 4'd0;
                        sub   <= '0;
                    end
                end
                default: state <= S_INI;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: stimulus queues expected snapshots and
// probe addresses, a negedge monitor compares them against what the DUT presents.
module tb_sprite_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, ack = 1'b0, tick = 1'b0, win = 1'b0, lose = 1'b0;
    logic [3:0] dir_req = 4'd0;
    logic       probe_ack = 1'b0, probe_wall = 1'b0;
    logic       probe_req, tick_drop;
    logic [9:0] probe_x, probe_y, pos_x, pos_y;
    logic [3:0] dir;
    logic [2:0] fsm_state;

    typedef struct {
        string      name;
        logic [2:0] st;
        logic [9:0] px;
        logic [9:0] py;
        logic [3:0] d;
        logic       preq;
        logic       tdrop;
    } snap_t;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
    } probe_t;

    snap_t  snap_q[$];
    probe_t probe_q[$];
    logic   done = 1'b0;
    int     checks = 0;
    int     fails = 0;

    always #5 clk = ~clk;

    sprite_motion_ctrl #(.X_MAX(366)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ack        (ack),
        .tick       (tick),
        .dir_req    (dir_req),
        .win        (win),
        .lose       (lose),
        .probe_req  (probe_req),
        .probe_x    (probe_x),
        .probe_y    (probe_y),
        .probe_ack  (probe_ack),
        .probe_wall (probe_wall),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .dir        (dir),
        .fsm_state  (fsm_state),
        .tick_drop  (tick_drop)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_snap(input string n, input int st, input int px, input int py,
                            input logic [3:0] d, input logic preq, input logic tdrop);
        snap_t s;
        s.name = n; s.st = st[2:0]; s.px = px[9:0]; s.py = py[9:0];
        s.d = d; s.preq = preq; s.tdrop = tdrop;
        snap_q.push_back(s);
    endtask

    task automatic exp_probe(input int x, input int y);
        probe_t p;
        p.x = x[9:0]; p.y = y[9:0];
        probe_q.push_back(p);
    endtask

    task automatic pulse_tick();
        tick = 1'b1; cyc(); tick = 1'b0;
    endtask

    // Monitor: compares each newly presented probe address and each queued snapshot.
    initial begin
        logic   last_req, last_ack;
        snap_t  s;
        probe_t p;
        last_req = 1'b0;
        last_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (probe_req && (!last_req || last_ack)) begin
                    checks++;
                    if (probe_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_probe: got probe at (%0d,%0d), required no probe", probe_x, probe_y);
                    end else begin
                        p = probe_q.pop_front();
                        if (probe_x !== p.x || probe_y !== p.y) begin
                            fails++;
                            $display("FAIL probe_addr: got (%0d,%0d), required (%0d,%0d)", probe_x, probe_y, p.x, p.y);
                        end
                    end
                end
                if (snap_q.size() > 0) begin
                    s = snap_q.pop_front();
                    checks++;
                    if (fsm_state !== s.st || pos_x !== s.px || pos_y !== s.py || dir !== s.d ||
                        probe_req !== s.preq || tick_drop !== s.tdrop) begin
                        fails++;
                        $display("FAIL %s: got st=%0d pos=(%0d,%0d) dir=%b req=%b drop=%b, required st=%0d pos=(%0d,%0d) dir=%b req=%b drop=%b",
                                 s.name, fsm_state, pos_x, pos_y, dir, probe_req, tick_drop,
                                 s.st, s.px, s.py, s.d, s.preq, s.tdrop);
                    end
                end
                if (done) begin
                    checks++;
                    if (snap_q.size() != 0 || probe_q.size() != 0) begin
                        fails++;
                        $display("FAIL queues_drained: got %0d snapshots and %0d probes left, required 0 and 0",
                                 snap_q.size(), probe_q.size());
                    end
                    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
                    $finish;
                end
            end
            last_req = probe_req;
            last_ack = probe_ack;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc(); cyc();
        reset = 1'b0;
        exp_snap("reset", 0, 300, 300, 4'b0000, 0, 0);
        cyc();

        start = 1'b1; cyc(); start = 1'b0;
        exp_snap("start", 1, 300, 300, 4'b0000, 0, 0);
        pulse_tick();
        exp_snap("idle_tick", 1, 300, 300, 4'b0000, 0, 0);

        // Right from spawn: probe east neighbour, answer clear after a few cycles.
        dir_req = 4'b0010; cyc(); dir_req = 4'b0000;
        exp_probe(328, 300);
        pulse_tick();
        exp_snap("probe_enter", 2, 300, 300, 4'b0000, 1, 0);
        cyc(); cyc();
        probe_ack = 1'b1; cyc(); probe_ack = 1'b0;
        exp_snap("accept_right", 3, 304, 300, 4'b0010, 0, 0);
        for (int i = 0; i < 6; i++) begin
            pulse_tick();
            exp_snap("move_right", 3, 304 + 4 * (i + 1), 300, 4'b0010, 0, 0);
            cyc();
        end

        // Turn up is walled, fall back to continuing right; pend=up stays stored.
        dir_req = 4'b0100; cyc(); dir_req = 4'b0000;
        exp_probe(328, 272);
        exp_probe(356, 300);
        pulse_tick();
        exp_snap("turn_probe", 2, 328, 300, 4'b0010, 1, 0);
        probe_ack = 1'b1; probe_wall = 1'b1; cyc(); probe_ack = 1'b0; probe_wall = 1'b0;
        exp_snap("retry_probe", 2, 328, 300, 4'b0010, 1, 0);
        cyc();
        probe_ack = 1'b1; cyc(); probe_ack = 1'b0;
        exp_snap("continue_right", 3, 332, 300, 4'b0010, 0, 0);
        for (int i = 0; i < 6; i++) begin
            pulse_tick();
            exp_snap("move_right2", 3, 332 + 4 * (i + 1), 300, 4'b0010, 0, 0);
            cyc();
        end

        // At 356 = X_MAX-10: retained up is retried first, then right is off-map.
        exp_probe(356, 272);
        pulse_tick();
        exp_snap("retained_up", 2, 356, 300, 4'b0010, 1, 0);
        probe_ack = 1'b1; probe_wall = 1'b1; cyc(); probe_ack = 1'b0; probe_wall = 1'b0;
        exp_snap("offmap_no_req", 2, 356, 300, 4'b0010, 0, 0);
        cyc();
        exp_snap("edge_stop", 1, 356, 300, 4'b0000, 0, 0);
        cyc();

        // Tick while probing is dropped; simultaneous win/lose resolves to LOSE.
        dir_req = 4'b1000; cyc(); dir_req = 4'b0000;
        exp_probe(328, 300);
        pulse_tick();
        exp_snap("probe_left", 2, 356, 300, 4'b0000, 1, 0);
        pulse_tick();
        exp_snap("tick_drop", 2, 356, 300, 4'b0000, 1, 1);
        win = 1'b1; lose = 1'b1; cyc(); win = 1'b0; lose = 1'b0;
        exp_snap("lose_wins", 5, 356, 300, 4'b0000, 0, 0);
        cyc();
        exp_snap("lose_hold", 5, 356, 300, 4'b0000, 0, 0);
        ack = 1'b1; cyc(); ack = 1'b0;
        exp_snap("lose_to_ini", 0, 300, 300, 4'b0000, 0, 0);
        cyc();

        // Back in play: pend was cleared, so an aligned tick must not probe.
        start = 1'b1; cyc(); start = 1'b0;
        exp_snap("restart", 1, 300, 300, 4'b0000, 0, 0);
        pulse_tick();
        exp_snap("pend_cleared", 1, 300, 300, 4'b0000, 0, 0);
        win = 1'b1; cyc(); win = 1'b0;
        exp_snap("win", 4, 300, 300, 4'b0000, 0, 0);
        ack = 1'b1; cyc(); ack = 1'b0;
        exp_snap("win_to_ini", 0, 300, 300, 4'b0000, 0, 0);
        cyc(); cyc();
        done = 1'b1;
        cyc(); cyc(); cyc();
    end

endmodule
